// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-bank responder.
//   state_t  : responder FSM states
//   I2C_ACK  : SDA level of an acknowledge bit (low)
//   I2C_NACK : SDA level of a not-acknowledge bit (high)
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_STOP
  } state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings the raw SCL/SDA pins into the clk domain and finds bus events.
// Each pin passes two synchronizer flops, then one history flop; events
// compare the synced level against the history level.
//   clk, rst_n : system clock, async active-low reset (flops reset to 1 = idle bus)
//   scl_in     : raw SCL pin
//   sda_in     : raw SDA pin
//   sda        : synchronized SDA level (data sampling)
//   scl_rise   : one-clk pulse, synced SCL 0 -> 1
//   scl_fall   : one-clk pulse, synced SCL 1 -> 0
//   start      : one-clk pulse, SDA falls while SCL is high
//   stop       : one-clk pulse, SDA rises while SCL is high
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  // [0],[1] synchronizer, [2] history
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end

  // SCL must be high in both the current and previous sample so that an
  // SDA change coinciding with an SCL edge is never taken as START/STOP.
  assign sda      = sda_q[1];
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];

endmodule

// File: rtl/i2c_responder.sv
// I2C target with a NUM_REGS x 8 register bank.
// Write transfer: address(W), pointer byte, then data bytes stored at an
// auto-incrementing pointer. Read transfer: address(R), then bytes read from
// the pointer, which advances on every master ACK. The pointer survives
// across transactions, so a pointer write + repeated START + read works.
//   clk, rst_n : system clock (>= 20x SCL), async active-low reset
//   scl_in     : raw SCL pin
//   sda_in     : raw SDA pin
//   sda_oe     : 1 = pull SDA low, 0 = release (open drain)
//   wr_pulse   : one-clk strobe per byte written into the bank
//   wr_addr    : bank index of that write
//   wr_data    : byte written
//   busy       : high from the address ACK until STOP
//   dbg_state  : current FSM state
// Handshake: there is no valid/ready pair here; wr_pulse is a pure strobe
// and wr_addr/wr_data are only meaningful in the cycle wr_pulse is high.
module i2c_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h48,
  parameter int         NUM_REGS = 16,
  localparam int        PW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  output logic          wr_pulse,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy,
  output state_t        dbg_state
);

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_bus_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  state_t        state, state_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic [PW-1:0] ptr, ptr_n;
  logic          rw, rw_n;
  logic          sda_oe_n, busy_n, wr_pulse_n;
  logic [PW-1:0] wr_addr_n;
  logic [7:0]    wr_data_n;
  logic          bank_we;
  logic [7:0]    bank [NUM_REGS];

  logic [7:0]    byte_in;
  logic [PW-1:0] ptr_inc;
  logic [7:0]    rd_byte, rd_next;

  assign byte_in   = {shift[6:0], sda};
  assign ptr_inc   = ptr + 1'b1;  // NUM_REGS is a power of 2, so this wraps
  assign rd_byte   = bank[ptr];
  assign rd_next   = bank[ptr_inc];
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      ptr      <= '0;
      rw       <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_pulse <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      ptr      <= ptr_n;
      rw       <= rw_n;
      sda_oe   <= sda_oe_n;
      busy     <= busy_n;
      wr_pulse <= wr_pulse_n;
      wr_addr  <= wr_addr_n;
      wr_data  <= wr_data_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
    end else if (bank_we) begin
      bank[ptr] <= byte_in;
    end
  end

  // sda_oe is only ever changed on a synced SCL fall (or by START/STOP,
  // which only occur once SDA has already been released).
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    ptr_n      = ptr;
    rw_n       = rw;
    sda_oe_n   = sda_oe;
    busy_n     = busy;
    wr_pulse_n = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    bank_we    = 1'b0;

    if (stop) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else if (start) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE, WAIT_STOP: begin
        end

        ADDR: begin
          if (scl_rise) begin
            shift_n   = byte_in;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_n = '0;
              if (byte_in[7:1] == DEV_ADDR) begin
                state_n = ADDR_ACK;
                rw_n    = byte_in[0];
                busy_n  = 1'b1;
              end else begin
                state_n = WAIT_STOP;
              end
            end
          end
        end

        // bit_cnt 0: the fall ending bit 8 -> drive ACK.
        // bit_cnt 1: the fall ending the ACK clock -> release and move on.
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd0) begin
              sda_oe_n  = ~I2C_ACK;
              bit_cnt_n = 4'd1;
            end else begin
              bit_cnt_n = '0;
              sda_oe_n  = 1'b0;
              case (state)
                ADDR_ACK: begin
                  if (rw) begin
                    // first read bit goes out on this same fall
                    state_n  = RDATA;
                    shift_n  = rd_byte;
                    sda_oe_n = ~rd_byte[7];
                  end else begin
                    state_n = PTR;
                  end
                end
                default: state_n = WDATA;
              endcase
            end
          end
        end

        PTR: begin
          if (scl_rise) begin
            shift_n   = byte_in;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_n = '0;
              ptr_n     = byte_in[PW-1:0];
              state_n   = PTR_ACK;
            end
          end
        end

        WDATA: begin
          if (scl_rise) begin
            shift_n   = byte_in;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_n  = '0;
              bank_we    = 1'b1;
              wr_pulse_n = 1'b1;
              wr_addr_n  = ptr;
              wr_data_n  = byte_in;
              ptr_n      = ptr_inc;
              state_n    = WDATA_ACK;
            end
          end
        end

        // bit_cnt counts master sampling edges. A fall with bit_cnt 0 only
        // happens after a reload from RDATA_ACK and puts out the MSB.
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd0) begin
              sda_oe_n = ~shift[7];
            end else if (bit_cnt == 4'd8) begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = '0;
              state_n   = RDATA_ACK;
            end else begin
              shift_n  = {shift[6:0], 1'b0};
              sda_oe_n = ~shift[6];
            end
          end
        end

        RDATA_ACK: begin
          if (scl_rise) begin
            if (sda == I2C_NACK) begin
              state_n = WAIT_STOP;
            end else begin
              ptr_n     = ptr_inc;
              shift_n   = rd_next;
              bit_cnt_n = '0;
              state_n   = RDATA;
            end
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_responder.sv
// Self-checking bench for i2c_responder: a bit-banged I2C master on an
// open-drain bus model, a reference register bank/pointer model, a write
// scoreboard and an sda_oe timing monitor.
module tb_i2c_responder;
  import i2c_pkg::*;

  localparam int         T     = 10;
  localparam int         NREGS = 16;
  localparam int         PW    = 4;
  localparam logic [6:0] DEV   = 7'h48;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic          sda_oe, wr_pulse, busy;
  logic [PW-1:0] wr_addr;
  logic [7:0]    wr_data;
  state_t        dbg_state;
  wire           sda_line = sda_m & ~sda_oe;

  int vectors = 0;
  int errors  = 0;
  int q       = 6;  // quarter SCL period in clk cycles (>= 5 keeps SCL <= clk/20)

  // reference model
  logic [7:0]        m_bank [NREGS];
  int                m_ptr;
  logic [PW+7:0]     exp_q [$];
  logic [PW+7:0]     sb_exp;
  time               fall_t = 0;
  time               el;
  logic              oe_seen = 1'b0;

  always #(T/2) clk = ~clk;

  i2c_responder #(.DEV_ADDR(DEV), .NUM_REGS(NREGS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_m),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .wr_pulse  (wr_pulse),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // write scoreboard
  always @(negedge clk) begin
    if (rst_n && wr_pulse === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr=%0h data=%0h, expected no write", wr_addr, wr_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({wr_addr, wr_data} !== sb_exp) begin
          errors++;
          $display("FAIL wr_pulse: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                   wr_addr, wr_data, sb_exp[PW+7:8], sb_exp[7:0]);
        end
      end
    end
  end

  // sda_oe may only move with SCL low, 3-4 clk after the raw SCL fall
  always @(negedge scl_m) fall_t = $time;
  always @(posedge sda_oe) oe_seen = 1'b1;
  always @(sda_oe) begin
    if (rst_n === 1'b1 && !$isunknown(sda_oe)) begin
      vectors++;
      el = $time - fall_t;
      if (scl_m !== 1'b0 || el <= 2*T || el > 4*T) begin
        errors++;
        $display("FAIL oe_timing: sda_oe->%0b scl=%0b %0t after fall, expected scl=0 and 3-4 clk",
                 sda_oe, scl_m, el);
      end
    end
  end

  initial begin
    #(90000*T);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bus master ----------------
  task automatic wait_q;
    repeat (q) @(negedge clk);
  endtask

  task automatic bus_start;
    sda_m = 1'b1; wait_q;
    scl_m = 1'b1; wait_q;
    sda_m = 1'b0; wait_q;
    scl_m = 1'b0; wait_q;
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; wait_q;
    scl_m = 1'b1; wait_q;
    sda_m = 1'b1; wait_q;
    wait_q;
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; wait_q;
    scl_m = 1'b1; wait_q;
    wait_q;
    scl_m = 1'b0; wait_q;
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; wait_q;
    scl_m = 1'b1; wait_q;
    b = sda_line; wait_q;
    scl_m = 1'b0; wait_q;
  endtask

  task automatic put_byte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    acked = (b == 1'b0);
  endtask

  task automatic get_byte(input logic master_ack, output logic [7:0] d);
    logic b;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      get_bit(b);
      d = {d[6:0], b};
    end
    put_bit(master_ack ? 1'b0 : 1'b1);
  endtask

  task automatic model_reset;
    for (int i = 0; i < NREGS; i++) m_bank[i] = 8'h00;
    m_ptr = 0;
  endtask

  // ---------------- transactions ----------------
  task automatic txn_write(input logic [7:0] pbyte, input logic [31:0] data, input int n);
    logic a;
    logic [7:0] d;
    bus_start;
    put_byte({DEV, 1'b0}, a);
    vectors++;
    if (a !== 1'b1) begin errors++; $display("FAIL wr_addr_ack: got ack=%0b, expected 1", a); end
    vectors++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_on: got %0b, expected 1", busy); end
    put_byte(pbyte, a);
    m_ptr = pbyte % NREGS;
    vectors++;
    if (a !== 1'b1) begin errors++; $display("FAIL ptr_ack: got ack=%0b, expected 1", a); end
    for (int k = 0; k < n; k++) begin
      d = data[31-8*k -: 8];
      exp_q.push_back({PW'(m_ptr), d});
      m_bank[m_ptr] = d;
      m_ptr = (m_ptr + 1) % NREGS;
      put_byte(d, a);
      vectors++;
      if (a !== 1'b1) begin errors++; $display("FAIL data_ack: byte %0d got ack=%0b, expected 1", k, a); end
    end
    bus_stop;
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_off: got %0b, expected 0", busy); end
    vectors++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL wr_missing: %0d writes outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic txn_read(input logic [7:0] pbyte, input int n, input bit set_ptr);
    logic a;
    logic [7:0] d;
    bus_start;
    if (set_ptr) begin
      put_byte({DEV, 1'b0}, a);
      put_byte(pbyte, a);
      m_ptr = pbyte % NREGS;
      vectors++;
      if (a !== 1'b1) begin errors++; $display("FAIL rd_ptr_ack: got ack=%0b, expected 1", a); end
      bus_start;  // repeated START
    end
    put_byte({DEV, 1'b1}, a);
    vectors++;
    if (a !== 1'b1) begin errors++; $display("FAIL rd_addr_ack: got ack=%0b, expected 1", a); end
    for (int k = 0; k < n; k++) begin
      get_byte(k < n-1, d);
      vectors++;
      if (d !== m_bank[m_ptr]) begin
        errors++; $display("FAIL rd_data: reg %0d got %02h, expected %02h", m_ptr, d, m_bank[m_ptr]);
      end
      if (k < n-1) m_ptr = (m_ptr + 1) % NREGS;
    end
    bus_stop;
    vectors++;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL rd_release: sda_oe=%0b, expected 0", sda_oe); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (5) @(negedge clk);
    vectors++;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_sda_oe: got %0b, expected 0", sda_oe); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b, expected 0", busy); end
    vectors++;
    if (wr_pulse !== 1'b0) begin errors++; $display("FAIL rst_wr_pulse: got %0b, expected 0", wr_pulse); end
    vectors++;
    if ({wr_addr, wr_data} !== '0) begin
      errors++; $display("FAIL rst_wr_bus: got addr=%0h data=%0h, expected 0", wr_addr, wr_data);
    end
    vectors++;
    if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d, expected IDLE", dbg_state); end
    vectors++;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_sda_oe_rel: got %0b, expected 0", sda_oe); end
  endtask

  task automatic test_write;
    txn_write(8'h03, 32'hA55A_0000, 2);
    txn_read(8'h03, 2, 1);
  endtask

  task automatic test_read_wrap;
    txn_write(8'h0F, {8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 16'h0}, 2);
    txn_read(8'h0F, 2, 1);
  endtask

  task automatic test_mismatch;
    logic a;
    oe_seen = 1'b0;
    bus_start;
    put_byte(8'h92, a);
    vectors++;
    if (a !== 1'b0) begin errors++; $display("FAIL mis_ack: got ack=%0b, expected 0", a); end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mis_busy: got %0b, expected 0", busy); end
    for (int k = 0; k < 2; k++) begin
      put_byte(8'($urandom), a);
      vectors++;
      if (a !== 1'b0) begin errors++; $display("FAIL mis_data_ack: got ack=%0b, expected 0", a); end
    end
    vectors++;
    if (oe_seen !== 1'b0) begin errors++; $display("FAIL mis_oe: sda_oe asserted=%0b, expected 0", oe_seen); end
    bus_stop;
    vectors++;
    if (dbg_state !== IDLE) begin errors++; $display("FAIL mis_state: got %0d, expected IDLE", dbg_state); end
  endtask

  task automatic test_abort;
    logic a;
    logic [7:0] p;
    p = 8'($urandom);
    bus_start;
    put_byte({DEV, 1'b0}, a);
    put_byte(p, a);
    m_ptr = p % NREGS;
    for (int i = 0; i < 4; i++) put_bit(1'($urandom));
    bus_stop;
    vectors++;
    if (dbg_state !== IDLE) begin errors++; $display("FAIL abort_state: got %0d, expected IDLE", dbg_state); end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b, expected 0", busy); end
    txn_read(p, 1, 1);  // aborted byte must not have landed
    txn_write(8'($urandom), $urandom, 2);
  endtask

  task automatic test_reset_mid;
    logic a, b;
    logic [7:0] ab;
    ab = {DEV, 1'b0};
    bus_start;
    for (int i = 7; i >= 0; i--) put_bit(ab[i]);
    vectors++;
    if (sda_oe !== 1'b1) begin errors++; $display("FAIL ack_drive: sda_oe=%0b, expected 1", sda_oe); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_async_oe: sda_oe=%0b, expected 0", sda_oe); end
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    oe_seen = 1'b0;
    get_bit(b);
    vectors++;
    if (b !== 1'b1) begin errors++; $display("FAIL rst_no_ack: sda=%0b, expected 1", b); end
    put_byte({DEV, 1'b0}, a);
    vectors++;
    if (a !== 1'b0) begin errors++; $display("FAIL rst_idle_ack: got ack=%0b, expected 0", a); end
    vectors++;
    if (oe_seen !== 1'b0) begin errors++; $display("FAIL rst_oe: sda_oe asserted=%0b, expected 0", oe_seen); end
    bus_stop;
    txn_read(8'($urandom), 2, 1);  // bank cleared by reset
    txn_write(8'($urandom), $urandom, 3);
  endtask

  task automatic test_random;
    for (int it = 0; it < 8; it++) begin
      q = $urandom_range(5, 8);
      case ($urandom_range(0, 2))
        0: txn_write(8'($urandom), $urandom, $urandom_range(1, 4));
        1: txn_read(8'($urandom), $urandom_range(1, 4), 1);
        default: txn_read(8'h00, $urandom_range(1, 3), 0);
      endcase
    end
    q = 6;
  endtask

  initial begin
    model_reset();
    test_reset;
    test_write;
    test_read_wrap;
    test_mismatch;
    test_abort;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
